// File: rtl/if_scratchpad_pkg.sv
// Shared types and default widths for the IF scratchpad slice.
package if_pkg;

  typedef enum logic [0:0] {
    IF_FILL  = 1'b0,
    IF_READY = 1'b1
  } if_state_t;

  localparam int IF_DATA_WIDTH    = 16;
  localparam int IF_POINTER_SIZE  = 4;
  localparam int IF_ROW_CNT_SIZE  = 16;

endpackage

// File: rtl/if_scratchpad_if.sv
// Bundle of the element write stream, row read port and row release handshake.
// master = producer/consumer side, slave = scratchpad side.
interface if_scratchpad_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int POINTER_SIZE = 4,
  parameter int ROW_CNT_SIZE = 16
);

  logic [POINTER_SIZE:0]   row_len;
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_ready;
  logic [POINTER_SIZE-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    row_valid;
  logic                    row_done;
  logic [ROW_CNT_SIZE-1:0] rows_completed;

  modport master (
    output row_len, in_valid, in_data, rd_ptr, row_done,
    input  in_ready, rd_data, row_valid, rows_completed
  );

  modport slave (
    input  row_len, in_valid, in_data, rd_ptr, row_done,
    output in_ready, rd_data, row_valid, rows_completed
  );

endinterface

// File: rtl/if_scratchpad_regfile.sv
// Row storage: one synchronous write port, one combinational read port, no reset.
module if_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write accepted elements; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_scratchpad.sv
// Input-feature row scratchpad: fills one row, holds it readable until released.
// Optional feature: define IF_SCRATCHPAD_OOB_CHECK_EN to add the sticky rd_oob flag.
//
// state    | meaning
// IF_FILL  | accepting elements of the next row
// IF_READY | complete row held, reads valid, waiting for row_done
module if_scratchpad
  import if_pkg::*;
#(
  parameter int DATA_WIDTH   = IF_DATA_WIDTH,
  parameter int POINTER_SIZE = IF_POINTER_SIZE,
  parameter int ROW_CNT_SIZE = IF_ROW_CNT_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  if_scratchpad_if.slave bus
`ifdef IF_SCRATCHPAD_OOB_CHECK_EN
  ,
  output logic         rd_oob
`endif
);

  if_state_t               state;
  logic [POINTER_SIZE-1:0] wr_cnt;
  logic [POINTER_SIZE:0]   len_q;
  logic [POINTER_SIZE:0]   eff_len;
  logic                    row_valid_q;
  logic [ROW_CNT_SIZE-1:0] rows_q;
  logic                    wr_en;
  logic                    last_wr;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // The first element of a row is governed by the live row_len; later ones by the latched copy.
  assign eff_len       = (wr_cnt == '0) ? bus.row_len : len_q;
  assign bus.in_ready  = (state == IF_FILL) && (eff_len != '0);
  assign wr_en         = bus.in_valid && bus.in_ready;
  assign last_wr       = ({1'b0, wr_cnt} == (eff_len - (POINTER_SIZE+1)'(1)));

  assign bus.row_valid      = row_valid_q;
  assign bus.rows_completed = rows_q;
  assign bus.rd_data        = row_valid_q ? mem_rdata : '0;

  if_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (POINTER_SIZE)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt),
    .wdata (bus.in_data),
    .raddr (bus.rd_ptr),
    .rdata (mem_rdata)
  );

  // Row sequencing: count writes in FILL, wait for release in READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IF_FILL;
      wr_cnt      <= '0;
      len_q       <= '0;
      row_valid_q <= 1'b0;
      rows_q      <= '0;
    end else begin
      case (state)
        IF_FILL: begin
          if (wr_en) begin
            if (wr_cnt == '0) len_q <= bus.row_len;
            if (last_wr) begin
              wr_cnt      <= '0;
              state       <= IF_READY;
              row_valid_q <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + POINTER_SIZE'(1);
            end
          end
        end
        IF_READY: begin
          if (bus.row_done) begin
            state       <= IF_FILL;
            row_valid_q <= 1'b0;
            rows_q      <= rows_q + ROW_CNT_SIZE'(1);
          end
        end
        default: state <= IF_FILL;
      endcase
    end
  end

`ifdef IF_SCRATCHPAD_OOB_CHECK_EN
  // Sticky flag for reads beyond the held row length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_oob <= 1'b0;
    end else if (row_valid_q && ({1'b0, bus.rd_ptr} >= len_q)) begin
      rd_oob <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/if_scratchpad.md
IF_SCRATCHPAD -- requirements
Module: if_scratchpad

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, input feature element width.
REQ-002 SHALL have parameter POINTER_SIZE, default 4, read/write pointer width; storage depth is 2**POINTER_SIZE.
REQ-003 SHALL have parameter ROW_CNT_SIZE, default 16, completed-row counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 row_len  input  POINTER_SIZE+1  elements per row (1..2**POINTER_SIZE); sampled at first write of a row.
REQ-007 in_valid  input  1  upstream element valid.
REQ-008 in_data  input  DATA_WIDTH  upstream element.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 rd_ptr  input  POINTER_SIZE  read address from the IF read address generator.
REQ-011 rd_data  output  DATA_WIDTH  element at rd_ptr.
REQ-012 row_valid  output  1  a complete row is held and readable.
REQ-013 row_done  input  1  consumer releases current row (same pulse that drives the generator's next_row).
REQ-014 rows_completed  output  ROW_CNT_SIZE  count of rows released.

Function
REQ-015 SHALL implement FSM with states FILL and READY; reset state FILL.
REQ-016 FILL: in_ready = 1 when latched-or-live row_len != 0, else 0; row_valid = 0.
REQ-017 Write handshake = in_valid && in_ready; on handshake, mem[wr_cnt] <= in_data and wr_cnt increments by 1.
REQ-018 row_len SHALL be latched into len_q on the handshake with wr_cnt == 0; later row_len changes within the row are ignored.
REQ-019 Handshake with wr_cnt == len_q-1 (or row_len-1 when wr_cnt == 0) SHALL move FSM to READY next cycle and clear wr_cnt.
REQ-020 READY: in_ready = 0, row_valid = 1; in_valid ignored, no memory write.
REQ-021 rd_data SHALL be combinational: mem[rd_ptr] when row_valid, else 0; zero-cycle read latency.
REQ-022 row_done in READY SHALL move FSM to FILL next cycle and increment rows_completed by 1 (wrap modulo 2**ROW_CNT_SIZE).
REQ-023 row_done in FILL SHALL be ignored (no state, counter or pointer change).
REQ-024 row_len == 0 in FILL with wr_cnt == 0: in_ready = 0, FSM stays FILL.
REQ-025 rd_ptr >= len_q in READY: rd_data returns stale memory contents; no error unless REQ-030 feature is compiled in.
REQ-026 Throughput: one element accepted per cycle in FILL; minimum row period len_q + 1 cycles (1 cycle READY if row_done asserted immediately).

Reset
REQ-027 rst SHALL asynchronously force: FSM FILL, wr_cnt 0, len_q 0, rows_completed 0, row_valid 0, rd_data 0, in_ready per REQ-016.
REQ-028 Reset mid-row SHALL discard partial row; storage array is not reset and its contents are don't-care.
REQ-029 First write SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro IF_SCRATCHPAD_OOB_CHECK_EN defined: output rd_oob (1 bit) SHALL be present, set on any cycle row_valid && rd_ptr >= len_q, sticky until rst (reset 0).
REQ-031 Macro undefined: rd_oob port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package if_pkg SHALL hold the FSM state enum (IF_FILL, IF_READY) and default DATA_WIDTH/POINTER_SIZE constants.
REQ-033 Storage SHALL be a sub-module if_regfile (one synchronous write port, one combinational read port, no reset); FSM, counters and checks stay in if_scratchpad.

Verification
REQ-034 row_len=4, in_valid held high, data 0x11,0x22,0x33,0x44 -> in_ready low from cycle 5, row_valid high; rd_ptr=2 gives rd_data=0x33.
REQ-035 In READY, in_valid=1 with 0x99 for 3 cycles -> no write; rd_ptr=0 still reads 0x11; row_done pulse -> FILL, rows_completed=1.
REQ-036 row_len changed 4->2 after first write -> row still completes after 4 writes; next row uses 2.
REQ-037 rst asserted after 2 of 4 writes -> row_valid=0, wr_cnt=0; next 4 writes form a full row at addresses 0..3.
REQ-038 row_done pulsed in FILL and row_len=0 held -> no state change, in_ready=0, rows_completed unchanged.
REQ-039 With IF_SCRATCHPAD_OOB_CHECK_EN, row_len=4, READY, rd_ptr=5 for one cycle -> rd_oob=1 and stays 1 until rst.
